// File: rtl/adder_share_arbiter.sv
// Shares one 32-bit ripple-carry adder among NUM_REQ requesters, with round-robin grant and a registered sum.
// Latency: the grant cycle is followed by one EXEC cycle, then the response is valid (best case one request per 3 cycles).
// Backpressure: RESP holds sum and id while rsp_ready is low; no new grant is issued until the response handshake.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_sum,
    output logic [ID_W-1:0]         rsp_id,
    input  logic                    rsp_ready
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_found;
    logic [ID_W:0]   cand;
    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic [31:0]     add_sum;
    logic [30:0]     carry;

    // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Ripple-carry adder; carry out of bit 31 is intentionally not formed.
    always_comb begin
        add_sum    = '0;
        carry      = '0;
        add_sum[0] = op_a[0] ^ op_b[0];
        carry[0]   = op_a[0] & op_b[0];
        for (int i = 1; i < 31; i++) begin
            add_sum[i] = op_a[i] ^ op_b[i] ^ carry[i-1];
            carry[i]   = (op_a[i] & op_b[i]) | (carry[i-1] & (op_a[i] ^ op_b[i]));
        end
        add_sum[31] = op_a[31] ^ op_b[31] ^ carry[30];
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    req_ready = NUM_REQ'(1) << gnt_idx;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            op_a     <= '0;
            op_b     <= '0;
            rsp_sum  <= '0;
            rsp_id   <= '0;
        end else begin
            if (state == IDLE && gnt_found) begin
                op_a     <= req_a[32*gnt_idx +: 32];
                op_b     <= req_b[32*gnt_idx +: 32];
                grant_id <= gnt_idx;
            end
            if (state == EXEC) begin
                rsp_sum <= add_sum;
                rsp_id  <= grant_id;
            end
            // Pointer moves on response handshake only, so a re-requester yields to the others.
            if (state == RESP && rsp_ready) begin
                rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

endmodule
